// File: rtl/sl_pkg.sv
// Shared types and helpers for the SL serial receiver feeding the async FIFO write port.
package sl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        CHECK    = 2'd2,
        ERR_WAIT = 2'd3
    } sl_state_e;

    // A falling edge on sl0 carries a 0, a falling edge on sl1 carries a 1.
    localparam logic SL0_BIT = 1'b0;
    localparam logic SL1_BIT = 1'b1;

    localparam int PAR_MAX_W = 32;

    // Data is zero-extended by callers; extra zeros do not change the XOR.
    function automatic logic odd_parity_ok(input logic [PAR_MAX_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/sl_line_sync.sv
// Two-flop synchronizers for both SL lines plus bit-event and line-violation detection.
module sl_line_sync
    import sl_pkg::*;
(
    input  logic wr_clk,
    input  logic rd_rst_n,
    input  logic sl0,
    input  logic sl1,
    output logic bit_valid,
    output logic bit_val,
    output logic line_viol,
    output logic lines_idle
);

    logic s0_meta, s0_sync, s0_prev;
    logic s1_meta, s1_sync, s1_prev;
    logic bit0_evt, bit1_evt;

    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            s0_meta <= 1'b1;
            s0_sync <= 1'b1;
            s0_prev <= 1'b1;
            s1_meta <= 1'b1;
            s1_sync <= 1'b1;
            s1_prev <= 1'b1;
        end else begin
            s0_meta <= sl0;
            s0_sync <= s0_meta;
            s0_prev <= s0_sync;
            s1_meta <= sl1;
            s1_sync <= s1_meta;
            s1_prev <= s1_sync;
        end
    end

    // A falling edge only counts as a bit while the other line is still idle.
    assign bit0_evt   = s0_prev & ~s0_sync & s1_sync;
    assign bit1_evt   = s1_prev & ~s1_sync & s0_sync;
    assign bit_valid  = bit0_evt | bit1_evt;
    assign bit_val    = bit1_evt ? SL1_BIT : SL0_BIT;
    assign line_viol  = ~s0_sync & ~s1_sync;
    assign lines_idle = s0_sync & s1_sync;

endmodule

// File: rtl/sl_rx_fifo_writer.sv
// SL serial word receiver: length/odd-parity check, pushes good words into the async FIFO write port.
module sl_rx_fifo_writer
    import sl_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int GAP_CYCLES = 64,
    parameter int CNT_W      = 8
) (
    input  logic                 wr_clk,
    input  logic                 rd_rst_n,
    input  logic                 en,
    input  logic                 sl0,
    input  logic                 sl1,
    output logic [DATA_SIZE-1:0] fifo_wr_data,
    output logic                 fifo_wr_inc,
    input  logic                 fifo_wr_full,
    input  logic                 err_clr,
    output logic                 parity_err,
    output logic                 line_err,
    output logic                 timeout_err,
    output logic                 overflow_err,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int BC_W = $clog2(DATA_SIZE + 1);
    localparam int GC_W = $clog2(GAP_CYCLES);

    logic bit_valid, bit_val, line_viol, lines_idle;

    sl_line_sync u_sync (
        .wr_clk     (wr_clk),
        .rd_rst_n   (rd_rst_n),
        .sl0        (sl0),
        .sl1        (sl1),
        .bit_valid  (bit_valid),
        .bit_val    (bit_val),
        .line_viol  (line_viol),
        .lines_idle (lines_idle)
    );

    sl_state_e            state, state_nxt;
    logic [DATA_SIZE-1:0] data_sr;
    logic                 par_q;
    logic [BC_W-1:0]      bit_cnt;
    logic [GC_W-1:0]      gap_cnt;

    logic load_first, shift_in, take_par, gap_clr, gap_inc;
    logic set_par, set_ovf, set_to, set_line, do_write;
    logic par_ok, gap_done, last_data_bit;

    assign par_ok        = odd_parity_ok(PAR_MAX_W'(data_sr), par_q);
    assign gap_done      = (gap_cnt == GC_W'(GAP_CYCLES - 1));
    assign last_data_bit = (bit_cnt == BC_W'(DATA_SIZE));

    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        shift_in   = 1'b0;
        take_par   = 1'b0;
        gap_clr    = 1'b0;
        gap_inc    = 1'b0;
        set_par    = 1'b0;
        set_ovf    = 1'b0;
        set_to     = 1'b0;
        set_line   = 1'b0;
        do_write   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else if (line_viol) begin
            state_nxt = ERR_WAIT;
            set_line  = 1'b1;
            gap_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bit_valid) begin
                        load_first = 1'b1;
                        gap_clr    = 1'b1;
                        state_nxt  = RECV;
                    end
                end
                RECV: begin
                    if (bit_valid) begin
                        gap_clr = 1'b1;
                        if (last_data_bit) begin
                            take_par  = 1'b1;
                            state_nxt = CHECK;
                        end else begin
                            shift_in = 1'b1;
                        end
                    end else if (gap_done) begin
                        set_to    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        gap_inc = 1'b1;
                    end
                end
                CHECK: begin
                    if (!par_ok)           set_par  = 1'b1;
                    else if (fifo_wr_full) set_ovf  = 1'b1;
                    else                   do_write = 1'b1;
                    // Back-to-back words: an event here starts the next word.
                    if (bit_valid) begin
                        load_first = 1'b1;
                        gap_clr    = 1'b1;
                        state_nxt  = RECV;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                ERR_WAIT: begin
                    if (!lines_idle) begin
                        gap_clr = 1'b1;
                    end else if (gap_done) begin
                        gap_clr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        gap_inc = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            data_sr <= '0;
            par_q   <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (load_first) begin
                data_sr <= {{(DATA_SIZE-1){1'b0}}, bit_val};
                bit_cnt <= BC_W'(1);
            end else if (shift_in) begin
                data_sr <= {data_sr[DATA_SIZE-2:0], bit_val};
                bit_cnt <= bit_cnt + BC_W'(1);
            end
            if (take_par) par_q <= bit_val;
            if (gap_clr)      gap_cnt <= '0;
            else if (gap_inc) gap_cnt <= gap_cnt + GC_W'(1);
        end
    end

    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            fifo_wr_inc  <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_inc <= do_write;
            if (do_write) fifo_wr_data <= data_sr;
        end
    end

    // Sticky flags: a same-cycle set beats err_clr.
    always_ff @(posedge wr_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            parity_err   <= 1'b0;
            line_err     <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            parity_err   <= set_par  | (parity_err   & ~err_clr);
            line_err     <= set_line | (line_err     & ~err_clr);
            timeout_err  <= set_to   | (timeout_err  & ~err_clr);
            overflow_err <= set_ovf  | (overflow_err & ~err_clr);
            if (set_ovf) begin
                if (err_clr)             drop_cnt <= CNT_W'(1);
                else if (~&drop_cnt)     drop_cnt <= drop_cnt + CNT_W'(1);
            end else if (err_clr) begin
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sl_rx_fifo_writer.sv
// Bench for sl_rx_fifo_writer: vector table, corner-case sequences, randomized words vs a word-level model.
module tb_sl_rx_fifo_writer;

    logic       wr_clk = 1'b0;
    logic       rd_rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sl0 = 1'b1;
    logic       sl1 = 1'b1;
    logic       fifo_wr_full = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] fifo_wr_data;
    logic       fifo_wr_inc;
    logic       parity_err, line_err, timeout_err, overflow_err;
    logic [7:0] drop_cnt;

    sl_rx_fifo_writer #(.DATA_SIZE(8), .GAP_CYCLES(64), .CNT_W(8)) dut (
        .wr_clk       (wr_clk),
        .rd_rst_n     (rd_rst_n),
        .en           (en),
        .sl0          (sl0),
        .sl1          (sl1),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_inc  (fifo_wr_inc),
        .fifo_wr_full (fifo_wr_full),
        .err_clr      (err_clr),
        .parity_err   (parity_err),
        .line_err     (line_err),
        .timeout_err  (timeout_err),
        .overflow_err (overflow_err),
        .drop_cnt     (drop_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] got_q[$];
    logic       prev_inc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge wr_clk) begin
        if (fifo_wr_inc === 1'b1) begin
            chk("no_back_to_back_inc", {31'd0, prev_inc}, 32'd0);
            got_q.push_back(fifo_wr_data);
        end
        prev_inc = fifo_wr_inc;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) sl1 = 1'b0;
        else   sl0 = 1'b0;
        cyc(2);
        sl0 = 1'b1;
        sl1 = 1'b1;
        cyc(2);
    endtask

    task automatic send_word(input logic [7:0] d, input logic p);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(p);
        cyc(8);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(1);
    endtask

    task automatic check_writes(input string name, input int exp_n, input logic [7:0] exp_d);
        chk({name, "_wr_count"}, got_q.size(), exp_n);
        if (exp_n == 1 && got_q.size() >= 1) chk({name, "_wr_data"}, {24'd0, got_q[0]}, {24'd0, exp_d});
        got_q.delete();
    endtask

    task automatic check_flags(input string name, input logic [3:0] exp_f, input logic [7:0] exp_drop);
        chk({name, "_flags_pltd"}, {28'd0, parity_err, line_err, timeout_err, overflow_err}, {28'd0, exp_f});
        chk({name, "_drop_cnt"}, {24'd0, drop_cnt}, {24'd0, exp_drop});
    endtask

    typedef struct {
        logic       clr;
        logic [7:0] data;
        logic       par;
        logic       full;
        logic       wr;
        logic       perr;
        logic       ovf;
        logic [7:0] drop;
    } vec_t;

    vec_t vecs[10];

    logic       m_perr, m_ovf;
    int         m_drop;
    logic [7:0] rd;
    logic       rp, rgood, rfull, rclr;
    int         exp_n;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[4] = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[5] = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3};
        vecs[6] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[7] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[9] = '{1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};

        cyc(3);
        chk("reset_inc_and_flags", {27'd0, fifo_wr_inc, parity_err, line_err, timeout_err, overflow_err}, 32'd0);
        chk("reset_data", {24'd0, fifo_wr_data}, 32'd0);
        chk("reset_drop", {24'd0, drop_cnt}, 32'd0);
        rd_rst_n = 1'b1;
        en = 1'b1;
        cyc(5);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].clr) pulse_clr();
            fifo_wr_full = vecs[v].full;
            send_word(vecs[v].data, vecs[v].par);
            fifo_wr_full = 1'b0;
            check_writes($sformatf("vec%0d", v), vecs[v].wr ? 1 : 0, vecs[v].data);
            check_flags($sformatf("vec%0d", v), {vecs[v].perr, 1'b0, 1'b0, vecs[v].ovf}, vecs[v].drop);
        end

        // Timeout after a partial word, then recovery.
        pulse_clr();
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        cyc(40);
        chk("timeout_not_early", {31'd0, timeout_err}, 32'd0);
        cyc(40);
        chk("timeout_set", {31'd0, timeout_err}, 32'd1);
        check_writes("timeout", 0, 8'h00);
        send_word(8'hFF, 1'b1);
        check_writes("after_timeout", 1, 8'hFF);

        // Line violation mid-word; bits inside the idle window are ignored.
        pulse_clr();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        sl0 = 1'b0;
        sl1 = 1'b0;
        cyc(3);
        sl0 = 1'b1;
        sl1 = 1'b1;
        cyc(4);
        chk("line_err_set", {31'd0, line_err}, 32'd1);
        cyc(6);
        send_bit(1'b1);
        send_bit(1'b0);
        cyc(8);
        check_writes("err_window", 0, 8'h00);
        chk("err_window_no_parity", {31'd0, parity_err}, 32'd0);
        cyc(80);
        send_word(8'h01, 1'b0);
        check_writes("after_line_err", 1, 8'h01);
        check_flags("after_line_err", 4'b0100, 8'd0);

        // Enable dropped mid-word discards the partial word silently.
        pulse_clr();
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        en = 1'b0;
        cyc(2);
        en = 1'b1;
        cyc(2);
        send_word(8'h3C, 1'b1);
        check_writes("after_en_low", 1, 8'h3C);
        check_flags("after_en_low", 4'b0000, 8'd0);

        // Async reset mid-word with a flag and non-zero data present.
        send_word(8'h00, 1'b0);
        check_writes("pre_reset_bad", 0, 8'h00);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        sl1 = 1'b0;
        #2;
        rd_rst_n = 1'b0;
        #1;
        chk("async_reset_flags", {27'd0, fifo_wr_inc, parity_err, line_err, timeout_err, overflow_err}, 32'd0);
        chk("async_reset_data", {24'd0, fifo_wr_data}, 32'd0);
        sl1 = 1'b1;
        cyc(3);
        rd_rst_n = 1'b1;
        cyc(5);
        send_word(8'h5A, 1'b1);
        check_writes("after_reset", 1, 8'h5A);
        check_flags("after_reset", 4'b0000, 8'd0);

        // Randomized words against a word-level model.
        pulse_clr();
        m_perr = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
        for (int w = 0; w < 24; w++) begin
            rclr  = ($urandom_range(0, 6) == 0);
            rd    = 8'($urandom);
            rgood = ($urandom_range(0, 3) != 0);
            rfull = ($urandom_range(0, 2) == 0);
            rp    = rgood ? ~(^rd) : (^rd);
            if (rclr) begin
                pulse_clr();
                m_perr = 1'b0;
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            exp_n = 0;
            if ((^{rd, rp}) != 1'b1) begin
                m_perr = 1'b1;
            end else if (rfull) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end else begin
                exp_n = 1;
            end
            fifo_wr_full = rfull;
            send_word(rd, rp);
            fifo_wr_full = 1'b0;
            check_writes($sformatf("rand%0d", w), exp_n, rd);
            check_flags($sformatf("rand%0d", w), {m_perr, 1'b0, 1'b0, m_ovf}, 8'(m_drop));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sl_rx_fifo_writer.md
Name: sl_rx_fifo_writer

Overview:
- Write-side producer for the team's async FIFO.
- Receives SL two-wire serial words (sl0 = "0" line, sl1 = "1" line, idle high), checks length and odd parity, and pushes good words into the FIFO write port (wr_data / wr_inc / wr_full).
- Runs entirely in the wr_clk domain; the FIFO read side is owned by the host-facing logic.
- Reports parity, line, timeout and overflow errors as sticky flags, plus a saturating count of dropped words.

Parameters:
- DATA_SIZE, 8: data bits per word; must match the FIFO DATA_SIZE.
- GAP_CYCLES, 64: wr_clk cycles without a new bit, inside a word, before the word is aborted.
- CNT_W, 8: width of drop_cnt.

Ports:
- wr_clk  in  1  block clock.
- rd_rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  receive enable.
- sl0  in  1  SL line 0, asynchronous, idle 1.
- sl1  in  1  SL line 1, asynchronous, idle 1.
- fifo_wr_data  out  DATA_SIZE  word to FIFO wr_data.
- fifo_wr_inc  out  1  one-cycle write strobe to FIFO wr_inc.
- fifo_wr_full  in  1  FIFO wr_full (registered in FIFO).
- err_clr  in  1  clears all sticky flags and drop_cnt.
- parity_err  out  1  sticky.
- line_err  out  1  sticky.
- timeout_err  out  1  sticky.
- overflow_err  out  1  sticky.
- drop_cnt  out  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (rd_rst_n low, async):
  - Sync flops = 1, state = IDLE.
  - fifo_wr_inc = 0, fifo_wr_data = 0.
  - All error flags = 0, drop_cnt = 0.
- Synchronizer: sl0 and sl1 each pass through 2 flops (s0, s1). Edge detection uses a third flop. Latency from pin to detected edge is 3 cycles.
- Bit events, detected on synced lines:
  - Falling edge of s0 while s1 = 1 → bit 0.
  - Falling edge of s1 while s0 = 1 → bit 1.
  - s0 = 0 and s1 = 0 in the same cycle → line violation.
- Word format: DATA_SIZE data bits, MSB first, then one parity bit. Parity is odd: XOR of all DATA_SIZE+1 bits must equal 1.
- FSM states:
  - IDLE: the first bit event loads the shift register, sets bit_cnt = 1, clears gap_cnt, and goes to RECV.
  - RECV:
    - Each bit event shifts the bit in, increments bit_cnt, and clears gap_cnt.
    - On the event with bit_cnt = DATA_SIZE, the bit is taken as parity and the FSM goes to CHECK.
    - gap_cnt increments every cycle with no event. When gap_cnt reaches GAP_CYCLES-1: timeout_err = 1, the word is discarded, the FSM goes to IDLE.
  - CHECK (1 cycle):
    - Parity bad: parity_err = 1, no write, go to IDLE.
    - Parity good and fifo_wr_full = 0: fifo_wr_data = data, fifo_wr_inc = 1 for exactly the next cycle, go to IDLE.
    - Parity good and fifo_wr_full = 1: overflow_err = 1, drop_cnt increments (saturating at all-ones), no write, go to IDLE.
  - ERR_WAIT:
    - Entered from any state on a line violation; line_err = 1 and any partial word is discarded.
    - Exits to IDLE only after s0 = s1 = 1 for GAP_CYCLES consecutive cycles.
- Latency: the parity-bit edge detected in cycle N gives CHECK in cycle N+1 and fifo_wr_inc high in cycle N+2. fifo_wr_data is stable while fifo_wr_inc = 1 and holds its value afterward.
- fifo_wr_inc is never high on two consecutive cycles. The minimum word spacing of DATA_SIZE+1 events covers the FIFO's one-cycle wr_full update lag.
- en = 0: the FSM is forced to IDLE and any partial word is discarded, with no flag. A fifo_wr_inc already scheduled for the current cycle still completes. The synchronizers keep running.
- err_clr: clears the flags and drop_cnt. If err_clr and a flag-set event occur in the same cycle, the set wins.
- A bit event arriving in the CHECK cycle is treated as the first bit of the next word (back-to-back words are allowed).

Decomposition:
- Package sl_pkg: FSM state enum (IDLE, RECV, CHECK, ERR_WAIT), bit-value constants for the sl0 and sl1 lines, and a helper function for the odd-parity reference.
- One sub-module, sl_line_sync: 2-flop sync for both lines plus the edge/violation detector. It outputs bit_valid, bit_val and line_viol.

Test Plan:
- DATA_SIZE = 8; send 0xA5 with parity 1 (four 1s, so parity bit 1) → one fifo_wr_inc, fifo_wr_data = 0xA5, no flags set.
- Send 0x3C with parity 1 (four 1s, so parity bit 1 is correct); then 0x3C with parity 0 → second word: parity_err = 1, no write.
- Hold fifo_wr_full = 1 and send three valid words → no fifo_wr_inc, overflow_err = 1, drop_cnt = 3. Pulse err_clr → all cleared.
- Send 4 bits, then idle for 64 cycles → timeout_err = 1. A subsequent full 0xFF word (parity 1) is written correctly.
- Drive sl0 = sl1 = 0 mid-word → line_err = 1, no write. Bit events during the following idle-high window of fewer than 64 cycles are ignored. After the window, 0x01 (parity 0) is written.
- Assert rd_rst_n low mid-word → outputs reset immediately (async). After release, a clean 0x5A (parity 1) is written once.
